mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port 1024x16 main memory between the instruction-fetch requester (read-only) and the data requester (read/write).
- Sits between the processor control/datapath and the memory wrapper.
- Owns the memory address/data/write-enable lines and performs round-robin arbitration, byte-to-word address conversion and range/alignment checking.
- Reports each read result on the requester's response lines. Keeps a sticky Overflow flag for illegal addresses.

Parameters:
DATA_W, 16, data width of memory and requesters
ADDR_W, 16, requester byte-address width
WORD_AW, 10, memory word-address width (words = 2**WORD_AW)

Ports:
CLK  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-low reset
FReq  in  1  fetch request; held with FAddr stable until FGnt
FAddr  in  16  fetch byte address
FGnt  out  1  fetch request accepted this cycle
FRvalid  out  1  FRdata valid this cycle
FRdata  out  16  fetch read data
FErr  out  1  fetch request rejected (illegal address)
DReq  in  1  data request; held with DAddr/DWdata/DWe stable until DGnt
DAddr  in  16  data byte address
DWdata  in  16  data write value
DWe  in  1  1 = write, 0 = read
DGnt  out  1  data request accepted this cycle
DRvalid  out  1  DRdata valid this cycle (reads only)
DRdata  out  16  data read data
DErr  out  1  data request rejected (illegal address)
MemAddr  out  10  word address to memory (= winner Addr[10:1])
MemData  out  16  write data to memory
MemWrite  out  1  memory write enable
MemQ  in  16  memory read data; valid one cycle after the address edge
Overflow  out  1  sticky: set when any illegal address is granted

Behaviour:
- States: IDLE, RD_WAIT.
- IDLE, cycle N:
  - Choose a winner among asserted requests.
  - Drive MemAddr combinationally from the winner.
  - Assert the winner's Gnt for cycle N only.
  - MemData = DWdata whenever data is the winner.
- Arbitration:
  - Single request wins.
  - Both requesting: the requester not granted last wins (round-robin pointer).
  - Pointer updates on every grant. Reset value favours fetch.
- Legal address: Addr[15:11] == 0 and Addr[0] == 0.
- Legal data write:
  - MemWrite = 1 in cycle N; memory updated at the end of N.
  - Stay in IDLE, so the next grant is possible in N+1.
- Legal read (fetch, or data with DWe = 0):
  - MemWrite = 0. Go to RD_WAIT.
  - In N+1: requester Rvalid = 1 and Rdata = MemQ, for one cycle.
  - Return to IDLE in N+2. No grants in RD_WAIT.
  - Read throughput: one read per 2 cycles.
- Illegal address:
  - Still granted in N, but MemWrite is forced to 0.
  - Requester Err = 1 in N+1 for one cycle.
  - For reads, Rvalid = 0 and Rdata = 0 in N+1. Stay in IDLE.
  - Overflow is set at the end of N and held until reset.
- Rdata outputs are 0 whenever Rvalid = 0.
- Idle memory outputs: MemAddr = 0, MemData = 0, MemWrite = 0.
- Reset (Reset = 0 at a rising edge):
  - State -> IDLE; pointer -> fetch-favoured; Overflow = 0.
  - All Gnt/Rvalid/Err outputs and Rdata outputs = 0, MemWrite = 0.
  - An in-flight read is dropped with no Rvalid.
  - Gnt is suppressed while Reset = 0.
- Simultaneous events:
  - A request arriving in RD_WAIT waits; it is granted in IDLE at N+2.
  - A requester may drop Req before Gnt; no side effect.

Decomposition:
- Shared package: state encoding (IDLE, RD_WAIT), requester ids (REQ_FETCH = 0, REQ_DATA = 1), address-legality constant (ADDR_LIMIT = 16'h0800).
- Sub-module: rr_arb2 — 2-input round-robin arbiter with pointer register; inputs req[1:0] and advance, output one-hot gnt.

Test Plan:
- Fetch read alone: preload word 3 = 16'hBEEF; FReq, FAddr = 16'h0006 -> FGnt at N, FRvalid at N+1 with FRdata = 16'hBEEF, MemAddr = 3 at N.
- Data write then read: DWe = 1, DAddr = 16'h0010, DWdata = 16'h1234 -> DGnt at N, MemWrite = 1 at N. Then a read of the same address -> DRdata = 16'h1234 at read-grant + 1.
- Contention: FReq and DReq held high together for 8 cycles (both reads) -> grants alternate F, D, F, D with a 2-cycle spacing. The first grant after reset goes to fetch.
- Illegal address: DAddr = 16'h0801 write -> DGnt, MemWrite = 0, DErr at N+1, Overflow = 1 and stays 1. FAddr = 16'h0003 -> FErr, FRvalid = 0.
- Reset mid-read: fetch granted at N, Reset = 0 at the N+1 edge -> FRvalid never asserted, state IDLE, Overflow = 0, memory contents unchanged.
- Back-to-back writes: DReq held with new address/data each cycle for 4 cycles -> DGnt every cycle, 4 memory words updated, read-back matches.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, requester ids,
// address-legality limit and the legality helper.
package mem_arbiter_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int WORD_AW = 10;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    // Requester ids double as bit positions in the request/grant vectors
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    // First byte address outside the 1024x16 memory
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = 16'h0800;

    // A byte address is usable only if it is inside the memory and word aligned
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return (addr < ADDR_LIMIT) && (addr[0] == 1'b0);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational so the winner
// can own the memory in the same cycle; the pointer remembers who should be
// favoured next time both requesters collide.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic       ptr_r;
    logic [1:0] gnt_s;

    // Pick a single winner; on a collision the pointer breaks the tie
    always_comb begin
        gnt_s = 2'b00;
        case (req)
            2'b01: gnt_s = 2'b01;
            2'b10: gnt_s = 2'b10;
            2'b11: begin
                if (ptr_r == REQ_DATA) begin
                    gnt_s = 2'b10;
                end else begin
                    gnt_s = 2'b01;
                end
            end
            default: gnt_s = 2'b00;
        endcase
    end

    assign gnt = gnt_s;

    // After any grant, favour the requester that was not just served
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= REQ_FETCH;
        end else if (advance && (gnt_s != 2'b00)) begin
            ptr_r <= gnt_s[REQ_FETCH] ? REQ_DATA : REQ_FETCH;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one single-port 1024x16 memory between the
// instruction-fetch port (read only) and the data port (read/write).
// Grants and the memory address are produced in the request cycle; read
// data is returned the following cycle straight from the memory output.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W_P  = DATA_W,
    parameter int ADDR_W_P  = ADDR_W,
    parameter int WORD_AW_P = WORD_AW
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 FReq,
    input  logic [ADDR_W_P-1:0]  FAddr,
    output logic                 FGnt,
    output logic                 FRvalid,
    output logic [DATA_W_P-1:0]  FRdata,
    output logic                 FErr,
    input  logic                 DReq,
    input  logic [ADDR_W_P-1:0]  DAddr,
    input  logic [DATA_W_P-1:0]  DWdata,
    input  logic                 DWe,
    output logic                 DGnt,
    output logic                 DRvalid,
    output logic [DATA_W_P-1:0]  DRdata,
    output logic                 DErr,
    output logic [WORD_AW_P-1:0] MemAddr,
    output logic [DATA_W_P-1:0]  MemData,
    output logic                 MemWrite,
    input  logic [DATA_W_P-1:0]  MemQ,
    output logic                 Overflow
);

    arb_state_e          state_r;
    logic                f_rvalid_r;
    logic                d_rvalid_r;
    logic                f_err_r;
    logic                d_err_r;
    logic                overflow_r;

    logic [1:0]          req_s;
    logic [1:0]          gnt_s;
    logic                f_win_s;
    logic                d_win_s;
    logic                any_win_s;
    logic [ADDR_W_P-1:0] win_addr_s;
    logic                legal_s;
    logic                is_read_s;

    // Requests are only visible in IDLE and never while reset is held
    assign req_s = {DReq, FReq} & {2{(state_r == IDLE) && Reset}};

    rr_arb2 u_rr_arb2 (
        .clk     (CLK),
        .rst_n   (Reset),
        .req     (req_s),
        .advance (any_win_s),
        .gnt     (gnt_s)
    );

    assign f_win_s   = gnt_s[REQ_FETCH];
    assign d_win_s   = gnt_s[REQ_DATA];
    assign any_win_s = f_win_s | d_win_s;

    // Steer the winner's address and classify the access
    always_comb begin
        win_addr_s = '0;
        legal_s    = 1'b0;
        is_read_s  = 1'b0;
        if (d_win_s) begin
            win_addr_s = DAddr;
            legal_s    = addr_legal(DAddr);
            is_read_s  = legal_s && !DWe;
        end else if (f_win_s) begin
            win_addr_s = FAddr;
            legal_s    = addr_legal(FAddr);
            is_read_s  = legal_s;
        end else begin
            win_addr_s = '0;
            legal_s    = 1'b0;
            is_read_s  = 1'b0;
        end
    end

    // Memory side: parked at zero unless someone holds the grant; an
    // illegal write must never reach the memory
    always_comb begin
        MemAddr  = '0;
        MemData  = '0;
        MemWrite = 1'b0;
        if (any_win_s) begin
            MemAddr  = win_addr_s[WORD_AW_P:1];
            MemData  = d_win_s ? DWdata : '0;
            MemWrite = d_win_s && DWe && legal_s;
        end else begin
            MemAddr  = '0;
            MemData  = '0;
            MemWrite = 1'b0;
        end
    end

    // Control FSM: reads park in RD_WAIT for the memory latency, writes and
    // rejected requests stay in IDLE; response strobes last one cycle
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_r    <= IDLE;
            f_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            f_err_r    <= 1'b0;
            d_err_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            f_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            f_err_r    <= 1'b0;
            d_err_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (is_read_s) begin
                        state_r    <= RD_WAIT;
                        f_rvalid_r <= f_win_s;
                        d_rvalid_r <= d_win_s;
                    end else begin
                        state_r <= IDLE;
                    end
                    if (any_win_s && !legal_s) begin
                        f_err_r    <= f_win_s;
                        d_err_r    <= d_win_s;
                        overflow_r <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign FGnt     = f_win_s;
    assign DGnt     = d_win_s;
    assign FRvalid  = f_rvalid_r;
    assign DRvalid  = d_rvalid_r;
    assign FErr     = f_err_r;
    assign DErr     = d_err_r;
    assign Overflow = overflow_r;

    // Read data comes straight off the memory but is forced to zero when not valid
    assign FRdata = f_rvalid_r ? MemQ : '0;
    assign DRdata = d_rvalid_r ? MemQ : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural
// 1024x16 synchronous-read memory attached to the memory port.
module tb_mem_arbiter;

    logic        CLK;
    logic        Reset;
    logic        FReq;
    logic [15:0] FAddr;
    logic        FGnt;
    logic        FRvalid;
    logic [15:0] FRdata;
    logic        FErr;
    logic        DReq;
    logic [15:0] DAddr;
    logic [15:0] DWdata;
    logic        DWe;
    logic        DGnt;
    logic        DRvalid;
    logic [15:0] DRdata;
    logic        DErr;
    logic [9:0]  MemAddr;
    logic [15:0] MemData;
    logic        MemWrite;
    logic [15:0] MemQ;
    logic        Overflow;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:1023];
    logic [15:0] mem_q;

    mem_arbiter dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .FReq     (FReq),
        .FAddr    (FAddr),
        .FGnt     (FGnt),
        .FRvalid  (FRvalid),
        .FRdata   (FRdata),
        .FErr     (FErr),
        .DReq     (DReq),
        .DAddr    (DAddr),
        .DWdata   (DWdata),
        .DWe      (DWe),
        .DGnt     (DGnt),
        .DRvalid  (DRvalid),
        .DRdata   (DRdata),
        .DErr     (DErr),
        .MemAddr  (MemAddr),
        .MemData  (MemData),
        .MemWrite (MemWrite),
        .MemQ     (MemQ),
        .Overflow (Overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: write at the edge, read data registered one cycle later
    always @(posedge CLK) begin
        if (MemWrite) mem[MemAddr] <= MemData;
        mem_q <= mem[MemAddr];
    end
    assign MemQ = mem_q;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] exp_fg;
    logic [7:0] exp_dg;
    logic [7:0] exp_fv;
    logic [7:0] exp_dv;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[3] = 16'hBEEF;
        mem_q  = 16'h0000;
        Reset = 1'b0; FReq = 1'b0; FAddr = 16'h0000;
        DReq = 1'b0; DAddr = 16'h0000; DWdata = 16'h0000; DWe = 1'b0;

        // Reset state
        step(); step();
        @(negedge CLK);
        check_val("rst_fgnt", FGnt, 1'b0);
        check_val("rst_dgnt", DGnt, 1'b0);
        check_val("rst_frvalid", FRvalid, 1'b0);
        check_val("rst_frdata", FRdata, 16'h0000);
        check_val("rst_ovf", Overflow, 1'b0);
        check_val("rst_memwr", MemWrite, 1'b0);
        check_val("rst_memaddr", MemAddr, 10'd0);
        check_val("rst_memdata", MemData, 16'h0000);
        step();
        Reset = 1'b1;

        // Fetch read alone
        FReq = 1'b1; FAddr = 16'h0006;
        @(negedge CLK);
        check_val("f_gnt", FGnt, 1'b1);
        check_val("f_memaddr", MemAddr, 10'd3);
        check_val("f_memwr", MemWrite, 1'b0);
        step();
        FReq = 1'b0;
        @(negedge CLK);
        check_val("f_rvalid", FRvalid, 1'b1);
        check_val("f_rdata", FRdata, 16'hBEEF);
        check_val("f_gnt_wait", FGnt, 1'b0);
        step();

        // Data write then read of the same address
        DReq = 1'b1; DAddr = 16'h0010; DWdata = 16'h1234; DWe = 1'b1;
        @(negedge CLK);
        check_val("dw_gnt", DGnt, 1'b1);
        check_val("dw_memwr", MemWrite, 1'b1);
        check_val("dw_memaddr", MemAddr, 10'd8);
        check_val("dw_memdata", MemData, 16'h1234);
        step();
        DWe = 1'b0;
        @(negedge CLK);
        check_val("dr_gnt", DGnt, 1'b1);
        check_val("dr_memwr", MemWrite, 1'b0);
        step();
        DReq = 1'b0;
        @(negedge CLK);
        check_val("dr_rvalid", DRvalid, 1'b1);
        check_val("dr_rdata", DRdata, 16'h1234);
        step();
        @(negedge CLK);
        check_val("dr_rvalid_end", DRvalid, 1'b0);
        check_val("dr_rdata_zero", DRdata, 16'h0000);
        step();

        // Illegal data write
        DReq = 1'b1; DAddr = 16'h0801; DWdata = 16'h5555; DWe = 1'b1;
        @(negedge CLK);
        check_val("ill_dgnt", DGnt, 1'b1);
        check_val("ill_memwr", MemWrite, 1'b0);
        check_val("ill_ovf_pre", Overflow, 1'b0);
        step();
        DReq = 1'b0; DWe = 1'b0;
        @(negedge CLK);
        check_val("ill_derr", DErr, 1'b1);
        check_val("ill_ovf", Overflow, 1'b1);
        check_val("ill_drvalid", DRvalid, 1'b0);
        step();
        // Misaligned fetch
        FReq = 1'b1; FAddr = 16'h0003;
        @(negedge CLK);
        check_val("mis_fgnt", FGnt, 1'b1);
        check_val("mis_derr_clr", DErr, 1'b0);
        step();
        FReq = 1'b0;
        @(negedge CLK);
        check_val("mis_ferr", FErr, 1'b1);
        check_val("mis_frvalid", FRvalid, 1'b0);
        check_val("mis_frdata", FRdata, 16'h0000);
        check_val("mis_ovf_sticky", Overflow, 1'b1);
        step();

        // Back-to-back writes, one grant per cycle
        DReq = 1'b1; DWe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            DAddr  = 16'h0020 + 16'(2 * i);
            DWdata = 16'hA000 + 16'(i);
            @(negedge CLK);
            check_val("b2b_dgnt", DGnt, 1'b1);
            check_val("b2b_memwr", MemWrite, 1'b1);
            step();
        end
        DReq = 1'b0; DWe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            DReq  = 1'b1;
            DAddr = 16'h0020 + 16'(2 * i);
            @(negedge CLK);
            check_val("b2b_rd_gnt", DGnt, 1'b1);
            step();
            DReq = 1'b0;
            @(negedge CLK);
            check_val("b2b_rd_data", DRdata, 16'hA000 + 16'(i));
            step();
        end

        // Reset during an in-flight fetch read
        FReq = 1'b1; FAddr = 16'h0006;
        @(negedge CLK);
        check_val("rmr_fgnt", FGnt, 1'b1);
        #1 Reset = 1'b0;
        step();
        @(negedge CLK);
        check_val("rmr_frvalid", FRvalid, 1'b0);
        check_val("rmr_fgnt_supp", FGnt, 1'b0);
        check_val("rmr_ovf", Overflow, 1'b0);
        step();
        Reset = 1'b1; FReq = 1'b0;
        @(negedge CLK);
        check_val("rmr_frvalid2", FRvalid, 1'b0);
        step();

        // Contention: both read, fetch first after reset, then alternate
        exp_fg = 8'b0001_0001;
        exp_dg = 8'b0100_0100;
        exp_fv = 8'b0010_0010;
        exp_dv = 8'b1000_1000;
        FReq = 1'b1; FAddr = 16'h0006;
        DReq = 1'b1; DAddr = 16'h0010; DWe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check_val("cnt_fgnt", FGnt, exp_fg[i]);
            check_val("cnt_dgnt", DGnt, exp_dg[i]);
            check_val("cnt_frvalid", FRvalid, exp_fv[i]);
            check_val("cnt_drvalid", DRvalid, exp_dv[i]);
            check_val("cnt_frdata", FRdata, exp_fv[i] ? 16'hBEEF : 16'h0000);
            check_val("cnt_drdata", DRdata, exp_dv[i] ? 16'h1234 : 16'h0000);
            step();
        end
        FReq = 1'b0; DReq = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
